// File: rtl/keypad_pkg.sv
// keypad_pkg: shared key codes, debouncer state encoding and digit helpers
package keypad_pkg;
  localparam logic [3:0] KEY_NONE = 4'd0;
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_ZERO = 4'd11;
  localparam logic [3:0] KEY_HASH = 4'd12;
  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} kstate_e;
  function automatic logic is_digit(input logic [3:0] code);
    return ((code >= 4'd1) && (code <= 4'd9)) || (code == KEY_ZERO);
  endfunction
  function automatic logic [3:0] key_to_bcd(input logic [3:0] code);
    return (code == KEY_ZERO) ? 4'd0 : code;
  endfunction
  function automatic logic [15:0] digit_mask(input int n);
    logic [31:0] m;
    m = (32'd1 << (4 * n)) - 32'd1;
    return m[15:0];
  endfunction
endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: synchronizes the raw scanner code and emits one event per debounced press
module key_debouncer
  import keypad_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [15:0] RELEASE_CYCLES  = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_data,
  output logic       key_event,
  output logic [3:0] key_code
);
  logic [3:0] sync1_q, sync2_q, synced;
  logic [3:0] cand_q, cand_d, code_q, code_d;
  logic [15:0] cnt_q, cnt_d;
  kstate_e state_q, state_d;
  // codes 13..15 are not real keys and read as no key
  assign synced = (sync2_q > KEY_HASH) ? KEY_NONE : sync2_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
    end else begin
      sync1_q <= key_data;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (synced != KEY_NONE) begin
        cand_d  = synced;
        cnt_d   = '0;
        state_d = DEBOUNCE;
      end
      DEBOUNCE: if (synced != cand_q) state_d = IDLE;
        else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) state_d = HELD;
        else cnt_d = cnt_q + 16'd1;
      HELD: if (synced == KEY_NONE) begin
        cnt_d   = '0;
        state_d = RELEASE;
      end
      RELEASE: if (synced != KEY_NONE) begin
        cnt_d   = '0;
        state_d = HELD;
      end else if (cnt_q == RELEASE_CYCLES - 16'd1) state_d = IDLE;
        else cnt_d = cnt_q + 16'd1;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    key_event = (state_q == DEBOUNCE) && (synced == cand_q) && (cnt_q == DEBOUNCE_CYCLES - 16'd1);
    code_d    = key_event ? cand_q : code_q;
    key_code  = code_d;
  end
endmodule

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: debounced key events feeding a BCD number-entry buffer with '*' clear and '#' commit
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [15:0] RELEASE_CYCLES  = 16'd50000,
  parameter int          MAX_DIGITS      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_data,
  output logic        key_event,
  output logic [3:0]  key_code,
  output logic [15:0] entry_digits,
  output logic [2:0]  entry_count,
  output logic        entry_valid,
  output logic [15:0] entry_value,
  output logic        entry_overflow
);
  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);
  logic [15:0] digits_q, digits_d, value_q, value_d;
  logic [2:0] count_q, count_d;
  logic valid_q, valid_d, ovf_q, ovf_d;
  logic dig, full, clear;
  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RELEASE_CYCLES (RELEASE_CYCLES)
  ) u_deb (
    .clk      (clk),
    .rst      (rst),
    .key_data (key_data),
    .key_event(key_event),
    .key_code (key_code)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q <= '0;
      value_q  <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      digits_q <= digits_d;
      value_q  <= value_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end
  always_comb begin
    dig      = key_event && is_digit(key_code);
    full     = count_q == MAX_CNT;
    clear    = key_event && ((key_code == KEY_STAR) || (key_code == KEY_HASH));
    digits_d = clear ? '0 : (dig && !full) ? {digits_q[11:0], key_to_bcd(key_code)} & digit_mask(MAX_DIGITS) : digits_q;
    count_d  = clear ? '0 : (dig && !full) ? count_q + 3'd1 : count_q;
    ovf_d    = clear ? 1'b0 : (dig && full) ? 1'b1 : ovf_q;
    valid_d  = key_event && (key_code == KEY_HASH);
    value_d  = valid_d ? digits_q : value_q;
  end
  assign entry_digits   = digits_q;
  assign entry_count    = count_q;
  assign entry_valid    = valid_q;
  assign entry_value    = value_q;
  assign entry_overflow = ovf_q;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: directed and random key presses checked against a press-level entry model
module tb_keypad_entry_ctrl;
  import keypad_pkg::*;
  localparam int D = 8;
  localparam int R = 8;
  localparam int MAXD = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] key_data = 4'd0;
  logic key_event, entry_valid, entry_overflow;
  logic [3:0] key_code;
  logic [15:0] entry_digits, entry_value;
  logic [2:0] entry_count;
  int checks = 0, errors = 0, cyc = 0;
  int ev_cnt = 0, ev_cyc = 0, ev_code = 0, val_cnt = 0;
  logic [15:0] val_seen = '0;
  int q[$];
  logic ovf_m = 1'b0;
  logic [15:0] value_m = '0;
  int c0, e0;

  keypad_entry_ctrl #(
    .DEBOUNCE_CYCLES(16'(D)),
    .RELEASE_CYCLES (16'(R)),
    .MAX_DIGITS     (MAXD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_data      (key_data),
    .key_event     (key_event),
    .key_code      (key_code),
    .entry_digits  (entry_digits),
    .entry_count   (entry_count),
    .entry_valid   (entry_valid),
    .entry_value   (entry_value),
    .entry_overflow(entry_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] k, input int n);
    key_data = k;
    repeat (n) begin
      @(negedge clk);
      cyc++;
      if (key_event) begin
        ev_cnt++;
        ev_cyc = cyc;
        ev_code = int'(key_code);
      end
      if (entry_valid) begin
        val_cnt++;
        val_seen = entry_value;
      end
    end
  endtask

  function automatic logic [15:0] model_digits();
    logic [15:0] v = '0;
    foreach (q[i]) v = {v[11:0], 4'(q[i])};
    return v;
  endfunction

  function automatic void model_apply(input int k);
    if ((k >= 1 && k <= 9) || k == 11) begin
      if (q.size() < MAXD) q.push_back(k == 11 ? 0 : k);
      else ovf_m = 1'b1;
    end else if (k == 10 || k == 12) begin
      if (k == 12) value_m = model_digits();
      q.delete();
      ovf_m = 1'b0;
    end
  endfunction

  task automatic check_buf(input string tag);
    chk({tag, "_digits"}, 32'(entry_digits), 32'(model_digits()));
    chk({tag, "_count"}, 32'(entry_count), 32'(q.size()));
    chk({tag, "_ovf"}, 32'(entry_overflow), 32'(ovf_m));
    chk({tag, "_value"}, 32'(entry_value), 32'(value_m));
  endtask

  task automatic press(input int k, input int hold, input int rel);
    int pc0, pe0, pv0;
    pc0 = cyc;
    pe0 = ev_cnt;
    pv0 = val_cnt;
    step(4'(k), hold);
    chk("press_events", 32'(ev_cnt - pe0), 32'd1);
    chk("press_latency", 32'(ev_cyc - pc0), 32'(D + 2));
    chk("press_code", 32'(ev_code), 32'(k));
    step(4'd0, rel);
    chk("release_events", 32'(ev_cnt - pe0), 32'd1);
    chk("code_held", 32'(key_code), 32'(k));
    model_apply(k);
    chk("valid_pulses", 32'(val_cnt - pv0), 32'(k == 12));
    if (k == 12) chk("commit_value", 32'(val_seen), 32'(value_m));
    check_buf("press");
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ev"}, 32'(key_event), 32'd0);
    chk({tag, "_code"}, 32'(key_code), 32'd0);
    chk({tag, "_digits"}, 32'(entry_digits), 32'd0);
    chk({tag, "_count"}, 32'(entry_count), 32'd0);
    chk({tag, "_valid"}, 32'(entry_valid), 32'd0);
    chk({tag, "_value"}, 32'(entry_value), 32'd0);
    chk({tag, "_ovf"}, 32'(entry_overflow), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    step(4'd0, 3);
    // single clean press
    press(5, D + 5, R + 4);
    // bouncing contact: only the final stable hold may produce an event
    e0 = ev_cnt;
    step(4'd5, 3); step(4'd0, 3); step(4'd5, 3); step(4'd0, 3);
    chk("bounce_no_early_event", 32'(ev_cnt - e0), 32'd0);
    c0 = cyc;
    step(4'd5, 20);
    chk("bounce_events", 32'(ev_cnt - e0), 32'd1);
    chk("bounce_latency", 32'(ev_cyc - c0), 32'(D + 2));
    step(4'd0, R + 4);
    model_apply(5);
    check_buf("bounce");
    // invalid codes never produce an event
    e0 = ev_cnt;
    step(4'd14, 20);
    step(4'd0, 5);
    chk("invalid_events", 32'(ev_cnt - e0), 32'd0);
    press(10, D + 5, R + 4);
    press(1, D + 5, R + 4);
    press(2, D + 5, R + 4);
    press(11, D + 5, R + 4);
    press(4, D + 5, R + 4);
    press(12, D + 5, R + 4);
    chk("commit_1204", 32'(entry_value), 32'h1204);
    for (int i = 0; i < 4; i++) press(9, D + 5, R + 4);
    press(3, D + 5, R + 4);
    chk("overflow_digits", 32'(entry_digits), 32'h9999);
    chk("overflow_flag", 32'(entry_overflow), 32'd1);
    press(10, D + 5, R + 4);
    // short glitch while held bounces through release back to held
    e0 = ev_cnt;
    c0 = cyc;
    step(4'd7, 50); step(4'd0, 2); step(4'd7, 48);
    chk("glitch_events", 32'(ev_cnt - e0), 32'd1);
    chk("glitch_latency", 32'(ev_cyc - c0), 32'(D + 2));
    step(4'd0, R + 4);
    model_apply(7);
    check_buf("glitch");
    // reset while held, key stays down and is re-debounced
    step(4'd3, D + 6);
    rst = 1'b1;
    #1;
    check_zero("midreset");
    q.delete();
    ovf_m = 1'b0;
    value_m = '0;
    @(negedge clk);
    rst = 1'b0;
    e0 = ev_cnt;
    c0 = cyc;
    step(4'd3, D + 6);
    chk("rehold_events", 32'(ev_cnt - e0), 32'd1);
    chk("rehold_latency", 32'(ev_cyc - c0), 32'(D + 2));
    step(4'd0, R + 4);
    model_apply(3);
    check_buf("rehold");
    repeat (40) press(int'($urandom_range(1, 12)), D + 4 + int'($urandom_range(0, 8)), R + 3 + int'($urandom_range(0, 8)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
Sits downstream of the 4x3 keypad scanner and turns its raw 4-bit key code into clean, debounced key events. Each digit press is packed into a BCD number-entry buffer. '*' clears the buffer and '#' commits the entry to the rest of the design as a one-cycle valid pulse. This block is the single point through which game and control logic reads the keypad.

Parameters:
DEBOUNCE_CYCLES, 16'd50000, clk cycles a new non-zero code must stay stable before it counts as a press (50000 is 1 ms at 50 MHz).
RELEASE_CYCLES, 16'd50000, clk cycles the code must read 0 before the key counts as released.
MAX_DIGITS, 4, capacity of the entry buffer in BCD digits (legal range 1..4).

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
key_data  in  4  raw scanner code: 0 none, 1..9 digit, 10 '*', 11 '0', 12 '#', 13..15 invalid
key_event  out  1  one-cycle pulse when a debounced press is accepted
key_code  out  4  code of the last accepted press; held between events
entry_digits  out  16  live BCD buffer, most recent digit in [3:0]; unused nibbles are 0
entry_count  out  3  number of digits currently in the buffer (0..MAX_DIGITS)
entry_valid  out  1  one-cycle pulse on '#' commit
entry_value  out  16  BCD value captured at commit; held until the next commit
entry_overflow  out  1  sticky flag: a digit was dropped because the buffer was full; cleared by '*', '#' or rst

Behaviour:
- Interface rule: one clock domain, clk. rst is asynchronous and active-high. key_data goes through a 2-flop synchronizer before any use; the synchronizer flops reset to 0.
- Reset values: every output is 0. FSM state is IDLE. Debounce counter is 0.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE.
  - IDLE: when the synced code is in 1..12, latch it as cand, clear the counter, go to DEBOUNCE. Codes 13..15 are treated as 0.
  - DEBOUNCE: counter increments each cycle while synced == cand.
    - synced != cand: go back to IDLE with no event.
    - counter reaches DEBOUNCE_CYCLES-1: go to HELD and set key_event=1 and key_code=cand in that same cycle.
  - HELD: no repeat events while the key is held. When synced == 0, clear the counter and go to RELEASE. A different non-zero code in HELD is ignored.
  - RELEASE: counter increments while synced == 0.
    - Any non-zero code: return to HELD and clear the counter.
    - counter reaches RELEASE_CYCLES-1: go to IDLE.
- Event latency: key_event is asserted exactly DEBOUNCE_CYCLES+2 cycles after a stable code first appears on key_data (2 synchronizer cycles plus DEBOUNCE_CYCLES).
- Entry buffer actions, all taken in the key_event cycle (results visible the next cycle):
  - Digit press (1..9 map to their own value, 11 maps to 0), when entry_count < MAX_DIGITS: entry_digits <= {entry_digits[11:0], d}, entry_count += 1.
  - Digit press when entry_count == MAX_DIGITS: buffer unchanged, entry_overflow <= 1.
  - '*': entry_digits <= 0, entry_count <= 0, entry_overflow <= 0.
  - '#': entry_value <= entry_digits, entry_valid pulses for 1 cycle, then the buffer clears exactly as for '*'.
  - '#' with entry_count == 0 still pulses entry_valid, with entry_value = 0.
- Leading '0' digits are stored and counted. entry_value is raw BCD; the block does no binary conversion.
- Nibbles above MAX_DIGITS are forced to 0 on every write.
- rst asserted mid-debounce or mid-hold aborts immediately. A key still held after rst releases is re-debounced from IDLE and produces a fresh event.

Decomposition:
- Shared package keypad_pkg holds:
  - key code constants KEY_NONE=0, KEY_STAR=10, KEY_ZERO=11, KEY_HASH=12;
  - FSM state encodings;
  - a function mapping a code to its BCD digit.
- One sub-module, key_debouncer, contains the synchronizer, the FSM and the counter, and outputs key_event/key_code.
- The top level holds the entry buffer logic.

Test Plan:
- Hold key_data=5 for DEBOUNCE_CYCLES+5 (set DEBOUNCE_CYCLES=RELEASE_CYCLES=8 for sim) -> one key_event exactly 10 cycles after the code appears; key_code=5; entry_digits=16'h0005; entry_count=1.
- Bounce key_data 5/0/5 at 3-cycle intervals, then hold 5 -> no event until 8 stable synced cycles; exactly one event overall.
- Enter keys 1,2,11,4, then #, each press and release fully debounced -> entry_valid pulse, entry_value=16'h1204, then entry_count=0 and entry_digits=0.
- Enter 9,9,9,9,3 -> entry_digits=16'h9999, entry_overflow=1. Then press * -> entry_digits=0, entry_count=0, entry_overflow=0.
- Hold 7 for 100 cycles, with a 2-cycle 0 glitch in the middle -> exactly one key_event; the FSM returns from RELEASE to HELD.
- Assert rst for 1 cycle while a key is in HELD, key still pressed -> all outputs 0 immediately; one fresh key_event after re-debounce.
